// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle RV32I core. Sequences FETCH -> DECODE ->
// EXECUTE -> (MEM) -> (WRITEBACK) and drives every datapath enable/select.
// The instruction class is captured in DECODE. Later states decode their
// outputs from state + class, plus the IR fields, which the datapath holds
// stable for the whole instruction.
// Both memories are handshaked with a bounded wait. A missing ready or an
// unsupported instruction parks the FSM in TRAP until reset.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              synchronous reset, active-high; forces all outputs to 0
//   op_code_i          IR[6:0]
//   funct3_i           IR[14:12]
//   funct7_i           IR[31:25]
//   alu_zero_i         ALU result == 0 (branch compare)
//   imem_ready_i       instruction word valid this cycle
//   dmem_ready_i       data access complete this cycle
//   imem_req_o         instruction fetch request
//   ir_wr_en_o         IR load pulse
//   pc_wr_en_o         PC load pulse
//   pc_src_sel_o       0: pc+4, 1: branch target
//   regf_wr_en_o       register file write
//   regf_wr_src_sel_o  0: ALU result, 1: dmem read data
//   alu_src2_sel_o     0: rs2, 1: immediate
//   alu_op_o           ALU operation {funct7[5], funct3} style encoding
//   mem_r_en_o         data memory read request
//   mem_wr_en_o        data memory write request
//   illegal_o          sticky: unsupported instruction decoded
//   timeout_o          sticky: memory ready not seen in time
//   state_o            current state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MemTimeout = 16,
    parameter int CntWidth   = $clog2(MemTimeout + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_code_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       alu_zero_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    output logic       imem_req_o,
    output logic       ir_wr_en_o,
    output logic       pc_wr_en_o,
    output logic       pc_src_sel_o,
    output logic       regf_wr_en_o,
    output logic       regf_wr_src_sel_o,
    output logic       alu_src2_sel_o,
    output logic [3:0] alu_op_o,
    output logic       mem_r_en_o,
    output logic       mem_wr_en_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_R,
        C_I,
        C_LOAD,
        C_STORE,
        C_BR
    } class_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MemTimeout);

    // C_NONE doubles as "illegal": unknown opcodes and branch funct3 other than BEQ/BNE.
    function automatic class_t decode_class(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_R:     return C_R;
            OP_I:     return C_I;
            OP_LOAD:  return C_LOAD;
            OP_STORE: return C_STORE;
            OP_BR:    return (f3 == 3'b000 || f3 == 3'b001) ? C_BR : C_NONE;
            default:  return C_NONE;
        endcase
    endfunction

    // Only SRAI (funct3 101) uses funct7[5] among the immediate ops; the other
    // I-type encodings put immediate bits there, so they must not leak into alu_op.
    function automatic logic [3:0] alu_op_for(input class_t c, input logic [2:0] f3,
                                              input logic f7_b5);
        case (c)
            C_R:     return {f7_b5, f3};
            C_I:     return {(f3 == 3'b101) ? f7_b5 : 1'b0, f3};
            C_BR:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    state_t                state, state_next;
    class_t                cls, cls_next;
    logic [CntWidth-1:0]   wait_cnt, wait_cnt_next;
    logic                  illegal, illegal_next;
    logic                  timeout, timeout_next;

    logic                  imem_req, ir_wr_en, pc_wr_en, pc_src_sel;
    logic                  regf_wr_en, regf_wr_src_sel, alu_src2_sel;
    logic [3:0]            alu_op;
    logic                  mem_r_en, mem_wr_en;
    logic                  take;

    // funct7 only contributes bit 5 to the ALU encoding.
    logic                  unused_funct7;
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    assign take = (funct3_i == 3'b000) ? alu_zero_i : !alu_zero_i;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_FETCH;
            cls      <= C_NONE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            cls      <= cls_next;
            wait_cnt <= wait_cnt_next;
            illegal  <= illegal_next;
            timeout  <= timeout_next;
        end
    end

    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next      = state;
        cls_next        = cls;
        wait_cnt_next   = wait_cnt;
        illegal_next    = illegal;
        timeout_next    = timeout;
        imem_req        = 1'b0;
        ir_wr_en        = 1'b0;
        pc_wr_en        = 1'b0;
        pc_src_sel      = 1'b0;
        regf_wr_en      = 1'b0;
        regf_wr_src_sel = 1'b0;
        alu_src2_sel    = 1'b0;
        alu_op          = 4'b0000;
        mem_r_en        = 1'b0;
        mem_wr_en       = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    ir_wr_en   = 1'b1;
                    pc_wr_en   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt == CntMax) begin
                    state_next   = S_TRAP;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            S_DECODE: begin
                if (decode_class(op_code_i, funct3_i) == C_NONE) begin
                    state_next   = S_TRAP;
                    illegal_next = 1'b1;
                end else begin
                    cls_next   = decode_class(op_code_i, funct3_i);
                    state_next = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                alu_src2_sel = (cls == C_I) || (cls == C_LOAD) || (cls == C_STORE);
                alu_op       = alu_op_for(cls, funct3_i, funct7_i[5]);
                case (cls)
                    C_R, C_I: state_next = S_WRITEBACK;
                    C_LOAD, C_STORE: begin
                        state_next    = S_MEM;
                        wait_cnt_next = '0;
                    end
                    C_BR: begin
                        pc_wr_en      = take;
                        pc_src_sel    = take;
                        state_next    = S_FETCH;
                        wait_cnt_next = '0;
                    end
                    default: begin
                        // Unreachable: DECODE never lets C_NONE through.
                        state_next   = S_TRAP;
                        illegal_next = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                // Address computation stays on the ALU for the whole access.
                alu_src2_sel = 1'b1;
                alu_op       = alu_op_for(cls, funct3_i, funct7_i[5]);
                mem_r_en     = (cls == C_LOAD);
                mem_wr_en    = (cls == C_STORE);
                if (dmem_ready_i) begin
                    if (cls == C_LOAD) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        state_next    = S_FETCH;
                        wait_cnt_next = '0;
                    end
                end else if (wait_cnt == CntMax) begin
                    state_next   = S_TRAP;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            S_WRITEBACK: begin
                // ALU controls stay put so an unregistered ALU result is still valid.
                regf_wr_en      = 1'b1;
                regf_wr_src_sel = (cls == C_LOAD);
                alu_src2_sel    = (cls == C_I) || (cls == C_LOAD);
                alu_op          = alu_op_for(cls, funct3_i, funct7_i[5]);
                state_next      = S_FETCH;
                wait_cnt_next   = '0;
            end

            S_TRAP: begin
                // Parked until reset; everything stays deasserted.
            end

            default: state_next = S_TRAP;
        endcase
    end

    // Reset is applied at the pins too, so outputs are already quiet during the
    // reset cycle itself (e.g. an abandoned MEM access drops immediately).
    assign imem_req_o        = imem_req        & ~rst_i;
    assign ir_wr_en_o        = ir_wr_en        & ~rst_i;
    assign pc_wr_en_o        = pc_wr_en        & ~rst_i;
    assign pc_src_sel_o      = pc_src_sel      & ~rst_i;
    assign regf_wr_en_o      = regf_wr_en      & ~rst_i;
    assign regf_wr_src_sel_o = regf_wr_src_sel & ~rst_i;
    assign alu_src2_sel_o    = alu_src2_sel    & ~rst_i;
    assign alu_op_o          = rst_i ? 4'b0000 : alu_op;
    assign mem_r_en_o        = mem_r_en        & ~rst_i;
    assign mem_wr_en_o       = mem_wr_en       & ~rst_i;
    assign illegal_o         = illegal         & ~rst_i;
    assign timeout_o         = timeout         & ~rst_i;
    assign state_o           = rst_i ? 3'd0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. A behavioural model tracks which
// phase of an instruction the controller should be in and what each output
// must be; a compare process checks every cycle against it. Directed
// sequences pin the model with literal expectations, then a randomized
// instruction/ready/reset stream exercises the rest.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;
    localparam int K_NONE = 0, K_R = 1, K_I = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_code_i = 7'd0;
    logic [2:0] funct3_i = 3'd0;
    logic [6:0] funct7_i = 7'd0;
    logic       alu_zero_i = 1'b0;
    logic       imem_ready_i = 1'b0;
    logic       dmem_ready_i = 1'b0;

    logic       imem_req_o, ir_wr_en_o, pc_wr_en_o, pc_src_sel_o;
    logic       regf_wr_en_o, regf_wr_src_sel_o, alu_src2_sel_o;
    logic [3:0] alu_op_o;
    logic       mem_r_en_o, mem_wr_en_o, illegal_o, timeout_o;
    logic [2:0] state_o;

    multicycle_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .op_code_i         (op_code_i),
        .funct3_i          (funct3_i),
        .funct7_i          (funct7_i),
        .alu_zero_i        (alu_zero_i),
        .imem_ready_i      (imem_ready_i),
        .dmem_ready_i      (dmem_ready_i),
        .imem_req_o        (imem_req_o),
        .ir_wr_en_o        (ir_wr_en_o),
        .pc_wr_en_o        (pc_wr_en_o),
        .pc_src_sel_o      (pc_src_sel_o),
        .regf_wr_en_o      (regf_wr_en_o),
        .regf_wr_src_sel_o (regf_wr_src_sel_o),
        .alu_src2_sel_o    (alu_src2_sel_o),
        .alu_op_o          (alu_op_o),
        .mem_r_en_o        (mem_r_en_o),
        .mem_wr_en_o       (mem_wr_en_o),
        .illegal_o         (illegal_o),
        .timeout_o         (timeout_o),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, ir_wr, pc_wr, pc_src, regf_wr, wr_src, src2;
        logic [3:0] alu_op;
        logic       mem_r, mem_w, illegal, timeout;
        logic [2:0] state;
    } outs_t;

    outs_t act;
    assign act = {imem_req_o, ir_wr_en_o, pc_wr_en_o, pc_src_sel_o, regf_wr_en_o,
                  regf_wr_src_sel_o, alu_src2_sel_o, alu_op_o, mem_r_en_o, mem_wr_en_o,
                  illegal_o, timeout_o, state_o};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbers are the debug codes the controller reports on state_o.
    int  m_phase = 0;
    int  m_cls   = K_NONE;
    int  m_wait  = 0;
    bit  m_ill   = 1'b0;
    bit  m_to    = 1'b0;
    bit  m_valid = 1'b0;
    bit  ir_load = 1'b0;

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3);
        if (op == 7'b0110011) return K_R;
        if (op == 7'b0010011) return K_I;
        if (op == 7'b0000011) return K_LOAD;
        if (op == 7'b0100011) return K_STORE;
        if (op == 7'b1100011 && f3 <= 3'd1) return K_BR;
        return K_NONE;
    endfunction

    function automatic logic [3:0] alu_ref(input int cls, input logic [2:0] f3, input logic [6:0] f7);
        if (cls == K_R) return {f7[5], f3};
        if (cls == K_I) return {(f3 == 3'd5) ? f7[5] : 1'b0, f3};
        if (cls == K_BR) return 4'b1000;
        return 4'b0000;
    endfunction

    // Expected outputs for the current cycle; care clears fields the model leaves open.
    task automatic model_expect(output outs_t e, output outs_t care);
        bit take;
        e    = '0;
        care = '1;
        if (rst_i) return;
        e.state   = 3'(m_phase);
        e.illegal = m_ill;
        e.timeout = m_to;
        if (!(m_phase == 2 || m_phase == 3 || m_phase == 5)) begin
            care.alu_op = '0;
            care.src2   = 1'b0;
        end
        case (m_phase)
            0: begin
                e.imem_req = 1'b1;
                e.ir_wr    = imem_ready_i;
                e.pc_wr    = imem_ready_i;
            end
            2: begin
                e.src2   = (m_cls == K_I || m_cls == K_LOAD || m_cls == K_STORE);
                e.alu_op = alu_ref(m_cls, funct3_i, funct7_i);
                if (m_cls == K_BR) begin
                    take     = (funct3_i == 3'd0) ? alu_zero_i : !alu_zero_i;
                    e.pc_wr  = take;
                    e.pc_src = take;
                end
            end
            3: begin
                e.src2  = 1'b1;
                e.mem_r = (m_cls == K_LOAD);
                e.mem_w = (m_cls == K_STORE);
            end
            4: begin
                e.regf_wr = 1'b1;
                e.wr_src  = (m_cls == K_LOAD);
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        if (rst_i) begin
            m_phase = 0; m_cls = K_NONE; m_wait = 0; m_ill = 0; m_to = 0; m_valid = 1;
            return;
        end
        if (!m_valid) return;
        case (m_phase)
            0: if (imem_ready_i) begin
                   m_phase = 1; ir_load = 1;
               end else if (m_wait == TIMEOUT) begin
                   m_phase = 5; m_to = 1;
               end else m_wait++;
            1: begin
                m_cls = classify(op_code_i, funct3_i);
                if (m_cls == K_NONE) begin m_phase = 5; m_ill = 1; end
                else m_phase = 2;
            end
            2: begin
                if (m_cls == K_R || m_cls == K_I) m_phase = 4;
                else if (m_cls == K_LOAD || m_cls == K_STORE) begin m_phase = 3; m_wait = 0; end
                else begin m_phase = 0; m_wait = 0; end
            end
            3: if (dmem_ready_i) begin
                   m_phase = (m_cls == K_LOAD) ? 4 : 0; m_wait = 0;
               end else if (m_wait == TIMEOUT) begin
                   m_phase = 5; m_to = 1;
               end else m_wait++;
            4: begin m_phase = 0; m_wait = 0; end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, between edges.
    initial forever begin
        outs_t e, care;
        @(negedge clk);
        #2;
        if (m_valid) begin
            model_expect(e, care);
            check("cycle_outs", 32'(act & care), 32'(e & care));
            check("single_write", 32'($countones({regf_wr_en_o, mem_wr_en_o,
                                                  pc_wr_en_o & ~ir_wr_en_o}) <= 1), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    logic [6:0] pend_op = 7'b0110011;
    logic [2:0] pend_f3 = 3'd0;
    logic [6:0] pend_f7 = 7'd0;
    bit  rnd_mode = 1'b0;
    bit  dir_imem = 1'b1;
    bit  dir_zero = 1'b0;
    int  dlow = 0;
    int  stall = 0;
    int  trap_cycles = 0;
    outs_t tr[$];

    task automatic pick_random();
        int r;
        r = int'($urandom_range(0, 19));
        pend_f3 = 3'($urandom_range(0, 7));
        pend_f7 = 7'($urandom_range(0, 127));
        if (r < 5) pend_op = 7'b0110011;
        else if (r < 9) pend_op = 7'b0010011;
        else if (r < 12) pend_op = 7'b0000011;
        else if (r < 15) pend_op = 7'b0100011;
        else if (r < 18) begin pend_op = 7'b1100011; pend_f3 = 3'($urandom_range(0, 1)); end
        else if (r < 19) begin pend_op = 7'b1100011; pend_f3 = 3'($urandom_range(2, 7)); end
        else pend_op = 7'($urandom_range(0, 127));
    endtask

    task automatic tick();
        @(negedge clk);
        if (ir_load) begin
            ir_load   = 1'b0;
            op_code_i = pend_op;
            funct3_i  = pend_f3;
            funct7_i  = pend_f7;
            if (rnd_mode) pick_random();
        end
        if (rnd_mode) begin
            if (m_phase == 5) trap_cycles++; else trap_cycles = 0;
            rst_i = ($urandom_range(0, 299) == 0) || (m_phase == 5 && trap_cycles > 4);
            if (stall > 0) begin
                stall--;
                imem_ready_i = 1'b0;
                dmem_ready_i = 1'b0;
            end else begin
                if ($urandom_range(0, 149) == 0) stall = int'($urandom_range(8, 24));
                imem_ready_i = ($urandom_range(0, 9) < 7);
                dmem_ready_i = ($urandom_range(0, 9) < 6);
            end
            alu_zero_i = 1'($urandom_range(0, 1));
        end else begin
            imem_ready_i = dir_imem;
            alu_zero_i   = dir_zero;
            if (m_phase == 3 && dlow > 0) begin
                dmem_ready_i = 1'b0;
                dlow--;
            end else dmem_ready_i = 1'b1;
        end
    endtask

    task automatic rec();
        tr.push_back(act);
    endtask

    task automatic run_trace(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            #3;
            rec();
        end
    endtask

    function automatic logic [31:0] state_seq(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s = (s << 3) | 32'(tr[i].state);
        return s;
    endfunction

    task automatic set_pend(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        pend_op = op; pend_f3 = f3; pend_f7 = f7;
    endtask

    initial begin
        int n;
        logic [31:0] exp_seq;

        // 1: reset for two cycles, then release
        set_pend(7'b0110011, 3'b000, 7'b0000000);
        tick(); #3; check("reset_outs_1", 32'(act), 32'd0);
        tick(); #3; check("reset_outs_2", 32'(act), 32'd0);
        rst_i = 1'b0;
        #1;
        check("release_state", 32'(state_o), 32'd0);
        check("release_imem_req", 32'(imem_req_o), 32'd1);

        // 2: ADD with immediate readies
        tr.delete(); rec(); run_trace(4);
        exp_seq = {17'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        check("add_states", state_seq(5), exp_seq);
        check("add_regf_wr", 32'({tr[0].regf_wr, tr[1].regf_wr, tr[2].regf_wr,
                                  tr[3].regf_wr, tr[4].regf_wr}), 32'b00010);
        check("add_alu_op", 32'(tr[2].alu_op), 32'd0);

        // 3: LW with dmem ready low for 3 cycles
        set_pend(7'b0000011, 3'b010, 7'b0000000);
        dlow = 3;
        tr.delete(); rec(); run_trace(8);
        exp_seq = {5'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        check("lw_states", state_seq(9), exp_seq);
        n = 0;
        foreach (tr[i]) if (tr[i].mem_r) n++;
        check("lw_mem_r_cycles", 32'(n), 32'd4);
        check("lw_wb_src", 32'({tr[7].regf_wr, tr[7].wr_src}), 32'b11);

        // 4: BEQ taken, then BNE not taken (zero=1 for both)
        set_pend(7'b1100011, 3'b000, 7'b0000000);
        dir_zero = 1'b1;
        tr.delete(); rec(); run_trace(3);
        exp_seq = {20'd0, 3'd0, 3'd1, 3'd2, 3'd0};
        check("beq_states", state_seq(4), exp_seq);
        check("beq_pc_write", 32'({tr[2].pc_wr, tr[2].pc_src}), 32'b11);
        check("beq_alu_op", 32'(tr[2].alu_op), 32'b1000);
        set_pend(7'b1100011, 3'b001, 7'b0000000);
        tr.delete(); rec(); run_trace(3);
        check("bne_states", state_seq(4), exp_seq);
        check("bne_pc_write", 32'({tr[2].pc_wr, tr[2].pc_src}), 32'b00);
        dir_zero = 1'b0;

        // 5a: illegal opcode parks in TRAP
        set_pend(7'b1111111, 3'b000, 7'b0000000);
        tr.delete(); rec(); run_trace(21);
        n = 0;
        for (int i = 2; i < 22; i++) if (tr[i].state == 3'd5 && tr[i].illegal) n++;
        check("illegal_trap_cycles", 32'(n), 32'd20);
        check("illegal_trap_quiet", 32'({tr[21].imem_req, tr[21].pc_wr, tr[21].alu_op}), 32'd0);

        // 5b: imem never ready -> TRAP after 17 FETCH cycles
        dir_imem = 1'b0;
        rst_i = 1'b1;
        tick(); #3;
        rst_i = 1'b0;
        #1;
        tr.delete(); rec(); run_trace(18);
        n = 0;
        for (int i = 0; i < 17; i++) if (tr[i].state == 3'd0 && !tr[i].timeout) n++;
        check("timeout_fetch_cycles", 32'(n), 32'd17);
        check("timeout_trap", 32'({tr[17].state, tr[17].timeout, tr[17].imem_req}), 32'b1011_0);
        dir_imem = 1'b1;

        // 6: SW, reset asserted while in MEM
        rst_i = 1'b1;
        tick(); #3;
        rst_i = 1'b0;
        set_pend(7'b0100011, 3'b010, 7'b0000000);
        dlow = 5;
        n = 0;
        while (m_phase != 3 && n < 10) begin
            tick(); #3; n++;
        end
        check("sw_reached_mem", 32'({state_o, mem_wr_en_o}), 32'b0111);
        rst_i = 1'b1;
        tick(); #3;
        rst_i = 1'b0;
        #1;
        check("sw_reset_drop", 32'({state_o, mem_wr_en_o, mem_r_en_o}), 32'd0);
        check("sw_reset_fetch", 32'(imem_req_o), 32'd1);
        dlow = 0;

        // Randomized run
        rnd_mode = 1'b1;
        pick_random();
        for (int i = 0; i < 4000; i++) tick();
        rst_i = 1'b0;
        tick();
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
